// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory read handshake and a one-entry valid/ready output to decode.
// Defining FETCH_TIMEOUT_EN adds a per-request cycle limit that ends the request with a cause-10 fault.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 32'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic [1:0]  inst_fault_cause,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic        mem_wait,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;

  localparam logic [1:0]  CAUSE_NONE       = 2'b00;
  localparam logic [1:0]  CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT    = 2'b10;
  localparam logic [31:0] TMO_LAST         = 32'(FETCH_TIMEOUT - 32'd1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;
  logic [1:0]  inst_cause_q, inst_cause_d;

  logic        misaligned_s;
  logic        tmo_hit_s;
  logic        fault_go_s;
  logic [1:0]  fault_cause_s;
  logic        mem_en_s;

  assign misaligned_s = (pc_q[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // Counter is zero outside REQ/WAIT, so it always starts a request at zero.
  always_comb begin
    if (state_q == REQ || state_q == WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end else begin
      tmo_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 32'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit_s = (tmo_cnt_q == TMO_LAST);
`else
  logic unused_tmo_s;
  assign tmo_hit_s    = 1'b0;
  assign unused_tmo_s = ^TMO_LAST;
`endif

  // A completing read (WAIT with mem_wait low) is excluded here, so completion beats timeout.
  assign fault_go_s    = ((state_q == REQ) && (misaligned_s || tmo_hit_s)) ||
                         ((state_q == WAIT) && mem_wait && tmo_hit_s);
  assign fault_cause_s = misaligned_s ? CAUSE_MISALIGNED : CAUSE_TIMEOUT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      halted_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 32'h0000_0000;
      inst_pc_q    <= 32'h0000_0000;
      inst_fault_q <= 1'b0;
      inst_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      halted_q     <= halted_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
      inst_cause_q <= inst_cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    halted_d     = halted_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    inst_cause_d = inst_cause_q;
    if (redirect_valid) begin
      state_d      = IDLE;
      pc_d         = redirect_pc;
      halted_d     = 1'b0;
      inst_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (halted_q) begin
            state_d = IDLE;
          end else begin
            state_d = REQ;
          end
        end
        REQ, WAIT: begin
          if (fault_go_s) begin
            state_d      = OUT;
            inst_valid_d = 1'b1;
            inst_data_d  = 32'h0000_0000;
            inst_pc_d    = pc_q;
            inst_fault_d = 1'b1;
            inst_cause_d = fault_cause_s;
          end else if ((state_q == WAIT) && !mem_wait) begin
            state_d      = OUT;
            inst_valid_d = 1'b1;
            inst_data_d  = mem_read_data;
            inst_pc_d    = pc_q;
            inst_fault_d = 1'b0;
            inst_cause_d = CAUSE_NONE;
            pc_d         = pc_q + 32'd4;
          end else if (mem_wait) begin
            state_d = WAIT;
          end else begin
            state_d = state_q;
          end
        end
        OUT: begin
          if (inst_ready) begin
            inst_valid_d = 1'b0;
            if (inst_fault_q) begin
              halted_d = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = REQ;
            end
          end else begin
            state_d = OUT;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Memory select decodes straight from state; a misaligned PC never reaches the memory.
  always_comb begin
    case (state_q)
      REQ: begin
        if (misaligned_s) begin
          mem_en_s = 1'b0;
        end else begin
          mem_en_s = 1'b1;
        end
      end
      WAIT:    mem_en_s = 1'b1;
      default: mem_en_s = 1'b0;
    endcase
  end

  assign mem_enable       = mem_en_s;
  assign mem_address      = mem_en_s ? pc_q : 32'h0000_0000;
  assign mem_rw           = 1'b0;
  assign mem_write_data   = 32'h0000_0000;
  assign inst_valid       = inst_valid_q;
  assign inst_data        = inst_data_q;
  assign inst_pc          = inst_pc_q;
  assign inst_fault       = inst_fault_q;
  assign inst_fault_cause = inst_cause_q;

endmodule
